// File: rtl/time_counter_pkg.sv
// rtl/time_counter_pkg.sv - shared types, default moduli and helpers for time_counter
package time_counter_pkg;

    typedef enum logic {
        HALT = 1'b0,
        RUN  = 1'b1
    } tc_state_t;

    localparam int DEF_SEC_MOD = 60;
    localparam int DEF_MIN_MOD = 60;
    localparam int DEF_HR_MOD  = 24;

    // Counter width for a modulus: clog2, never narrower than one bit.
    function automatic int cnt_w(input int modulus);
        return (modulus <= 2) ? 1 : $clog2(modulus);
    endfunction

    // True when the next step in the given direction wraps the counter.
    function automatic logic at_end(input int cnt, input int modulus, input logic dir);
        return dir ? (cnt == 0) : (cnt == modulus - 1);
    endfunction

endpackage

// File: rtl/time_counter_if.sv
// rtl/time_counter_if.sv - control/load/count bundle between a driver and time_counter
// Ports (via modports):
//   master : drives start, stop, dir, load, load_s/m/h; observes counts, pulses, running
//   slave  : the counter side, opposite directions
interface time_counter_if
    import time_counter_pkg::*;
#(
    parameter int SEC_MOD = DEF_SEC_MOD,
    parameter int MIN_MOD = DEF_MIN_MOD,
    parameter int HR_MOD  = DEF_HR_MOD
);
    localparam int SW = cnt_w(SEC_MOD);
    localparam int MW = cnt_w(MIN_MOD);
    localparam int HW = cnt_w(HR_MOD);

    logic          start;
    logic          stop;
    logic          dir;
    logic          load;
    logic [SW-1:0] load_s;
    logic [MW-1:0] load_m;
    logic [HW-1:0] load_h;
    logic [SW-1:0] second;
    logic [MW-1:0] minute;
    logic [HW-1:0] hour;
    logic          inc_m;
    logic          inc_h;
    logic          inc_d;
    logic          load_err;
    logic          running;

    modport master (
        output start, stop, dir, load, load_s, load_m, load_h,
        input  second, minute, hour, inc_m, inc_h, inc_d, load_err, running
    );

    modport slave (
        input  start, stop, dir, load, load_s, load_m, load_h,
        output second, minute, hour, inc_m, inc_h, inc_d, load_err, running
    );

endinterface

// File: rtl/time_counter_mod_counter.sv
// rtl/time_counter_mod_counter.sv - modulo-MOD up/down counter with clamped load
// Ports:
//   clk_div, rst_n : clock, synchronous active-low reset
//   en, dir        : step enable, 0 = up / 1 = down
//   load, load_val : synchronous load (priority over en), clamped to MOD-1
//   cnt            : registered count
//   wrap           : registered one-cycle pulse when the step wrapped
//   clamp          : registered one-cycle pulse when a load was clamped
module mod_counter
    import time_counter_pkg::*;
#(
    parameter int  MOD = DEF_SEC_MOD,
    localparam int W   = cnt_w(MOD)
) (
    input  logic         clk_div,
    input  logic         rst_n,
    input  logic         en,
    input  logic         dir,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         clamp
);

    localparam logic [W-1:0] TOP = W'(MOD - 1);

    logic over;
    logic last;

    // Compared at 32 bits so a field that cannot exceed MOD (e.g. MOD=256) is harmless.
    assign over = (32'(load_val) >= 32'(MOD));
    assign last = at_end(32'(cnt), MOD, dir);

    always_ff @(posedge clk_div) begin
        if (!rst_n) begin
            cnt   <= '0;
            wrap  <= 1'b0;
            clamp <= 1'b0;
        end else begin
            wrap  <= 1'b0;
            clamp <= 1'b0;
            if (load) begin
                cnt   <= over ? TOP : load_val;
                clamp <= over;
            end else if (en) begin
                wrap <= last;
                if (last) begin
                    cnt <= dir ? TOP : '0;
                end else begin
                    cnt <= dir ? (cnt - W'(1)) : (cnt + W'(1));
                end
            end
        end
    end

endmodule

// File: rtl/time_counter.sv
// rtl/time_counter.sv - hour:minute:second counter with HALT/RUN control and clamped load
// Ports:
//   clk_div : clock, all state changes on its rising edge
//   rst_n   : synchronous active-low reset
//   bus     : time_counter_if.slave (start/stop/dir/load/load_* in;
//             second/minute/hour, inc_m/inc_h/inc_d, load_err, running out)
module time_counter
    import time_counter_pkg::*;
#(
    parameter int SEC_MOD = DEF_SEC_MOD,
    parameter int MIN_MOD = DEF_MIN_MOD,
    parameter int HR_MOD  = DEF_HR_MOD
) (
    input  logic          clk_div,
    input  logic          rst_n,
    time_counter_if.slave bus
);

    tc_state_t state_q;
    tc_state_t state_d;

    logic run;
    logic sec_end;
    logic min_end;
    logic en_m;
    logic en_h;
    logic clamp_s;
    logic clamp_m;
    logic clamp_h;

    always_ff @(posedge clk_div) begin
        if (!rst_n) begin
            state_q <= HALT;
        end else begin
            state_q <= state_d;
        end
    end

    // Stop dominates start; load never affects the state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HALT:    if (bus.start && !bus.stop) state_d = RUN;
            RUN:     if (bus.stop) state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    assign run = (state_q == RUN);

    // Carry/borrow chain: a higher digit steps only when every lower digit wraps now.
    assign sec_end = at_end(32'(bus.second), SEC_MOD, bus.dir);
    assign min_end = at_end(32'(bus.minute), MIN_MOD, bus.dir);
    assign en_m    = run && sec_end;
    assign en_h    = en_m && min_end;

    mod_counter #(.MOD(SEC_MOD)) u_sec (
        .clk_div  (clk_div),
        .rst_n    (rst_n),
        .en       (run),
        .dir      (bus.dir),
        .load     (bus.load),
        .load_val (bus.load_s),
        .cnt      (bus.second),
        .wrap     (bus.inc_m),
        .clamp    (clamp_s)
    );

    mod_counter #(.MOD(MIN_MOD)) u_min (
        .clk_div  (clk_div),
        .rst_n    (rst_n),
        .en       (en_m),
        .dir      (bus.dir),
        .load     (bus.load),
        .load_val (bus.load_m),
        .cnt      (bus.minute),
        .wrap     (bus.inc_h),
        .clamp    (clamp_m)
    );

    mod_counter #(.MOD(HR_MOD)) u_hr (
        .clk_div  (clk_div),
        .rst_n    (rst_n),
        .en       (en_h),
        .dir      (bus.dir),
        .load     (bus.load),
        .load_val (bus.load_h),
        .cnt      (bus.hour),
        .wrap     (bus.inc_d),
        .clamp    (clamp_h)
    );

    // All three clamp flags are flop outputs, so the OR is a clean one-cycle pulse.
    assign bus.load_err = clamp_s || clamp_m || clamp_h;
    assign bus.running  = run;

endmodule

// File: tb/tb_time_counter.sv
// tb/tb_time_counter.sv - self-checking bench for time_counter (default and 10/60/12 moduli)
module tb_time_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start;
    logic stop;
    logic dir;
    logic load;
    int   ld_s [2];
    int   ld_m [2];
    int   ld_h [2];

    int errors = 0;
    int checks = 0;

    // Reference model: time as a single count of seconds within one day.
    int smod [2] = '{60, 10};
    int mmod [2] = '{60, 60};
    int hmod [2] = '{24, 12};
    int m_t  [2];
    bit m_run [2];
    bit m_im [2];
    bit m_ih [2];
    bit m_id [2];
    bit m_err [2];

    time_counter_if #(.SEC_MOD(60), .MIN_MOD(60), .HR_MOD(24)) ifa ();
    time_counter_if #(.SEC_MOD(10), .MIN_MOD(60), .HR_MOD(12)) ifb ();

    assign ifa.start  = start;
    assign ifa.stop   = stop;
    assign ifa.dir    = dir;
    assign ifa.load   = load;
    assign ifa.load_s = 6'(ld_s[0]);
    assign ifa.load_m = 6'(ld_m[0]);
    assign ifa.load_h = 5'(ld_h[0]);
    assign ifb.start  = start;
    assign ifb.stop   = stop;
    assign ifb.dir    = dir;
    assign ifb.load   = load;
    assign ifb.load_s = 4'(ld_s[1]);
    assign ifb.load_m = 6'(ld_m[1]);
    assign ifb.load_h = 4'(ld_h[1]);

    time_counter #(.SEC_MOD(60), .MIN_MOD(60), .HR_MOD(24)) dut_a (
        .clk_div (clk),
        .rst_n   (rst_n),
        .bus     (ifa.slave)
    );

    time_counter #(.SEC_MOD(10), .MIN_MOD(60), .HR_MOD(12)) dut_b (
        .clk_div (clk),
        .rst_n   (rst_n),
        .bus     (ifb.slave)
    );

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[dut%0d] observed=%0d expected=%0d", tag, i, obs, exp);
        end
    endtask

    function automatic int clampv(input int v, input int modulus);
        return (v >= modulus) ? modulus - 1 : v;
    endfunction

    task automatic model_edge(input int i);
        int  tot;
        int  s;
        int  m;
        bit  nxt_run;
        tot = smod[i] * mmod[i] * hmod[i];
        m_im[i] = 0; m_ih[i] = 0; m_id[i] = 0; m_err[i] = 0;
        if (!rst_n) begin
            m_t[i]   = 0;
            m_run[i] = 0;
            return;
        end
        nxt_run = m_run[i] ? !stop : (start && !stop);
        if (load) begin
            m_t[i] = (clampv(ld_h[i], hmod[i]) * mmod[i] + clampv(ld_m[i], mmod[i])) * smod[i]
                     + clampv(ld_s[i], smod[i]);
            m_err[i] = (ld_s[i] >= smod[i]) || (ld_m[i] >= mmod[i]) || (ld_h[i] >= hmod[i]);
        end else if (m_run[i]) begin
            m_t[i] = dir ? (m_t[i] + tot - 1) % tot : (m_t[i] + 1) % tot;
            s = m_t[i] % smod[i];
            m = (m_t[i] / smod[i]) % mmod[i];
            if (!dir) begin
                m_im[i] = (s == 0);
                m_ih[i] = (s == 0) && (m == 0);
                m_id[i] = (m_t[i] == 0);
            end else begin
                m_im[i] = (s == smod[i] - 1);
                m_ih[i] = (s == smod[i] - 1) && (m == mmod[i] - 1);
                m_id[i] = (m_t[i] == tot - 1);
            end
        end
        m_run[i] = nxt_run;
    endtask

    task automatic check_one(input int i, input logic [31:0] s, input logic [31:0] m,
                             input logic [31:0] h, input logic im, input logic ih,
                             input logic id, input logic le, input logic rn);
        chk("second",   i, s, 32'(m_t[i] % smod[i]));
        chk("minute",   i, m, 32'((m_t[i] / smod[i]) % mmod[i]));
        chk("hour",     i, h, 32'(m_t[i] / (smod[i] * mmod[i])));
        chk("inc_m",    i, 32'(im), 32'(m_im[i]));
        chk("inc_h",    i, 32'(ih), 32'(m_ih[i]));
        chk("inc_d",    i, 32'(id), 32'(m_id[i]));
        chk("load_err", i, 32'(le), 32'(m_err[i]));
        chk("running",  i, 32'(rn), 32'(m_run[i]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_one(0, 32'(ifa.second), 32'(ifa.minute), 32'(ifa.hour), ifa.inc_m, ifa.inc_h,
                  ifa.inc_d, ifa.load_err, ifa.running);
        check_one(1, 32'(ifb.second), 32'(ifb.minute), 32'(ifb.hour), ifb.inc_m, ifb.inc_h,
                  ifb.inc_d, ifb.load_err, ifb.running);
    endtask

    task automatic set_load(input int i, input int h, input int m, input int s);
        ld_h[i] = h;
        ld_m[i] = m;
        ld_s[i] = s;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0; load = 1'b0;
        set_load(0, 0, 0, 0);
        set_load(1, 0, 0, 0);

        // Reset state, then start and count up through a seconds wrap.
        step();
        rst_n = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        repeat (59) step();
        step();
        stop = 1'b1; step(); stop = 1'b0;

        // Day rollover upward from the last second of the day.
        set_load(0, 23, 59, 59);
        set_load(1, 11, 59, 9);
        load = 1'b1; step(); load = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        step();

        // Day rollover downward, then a direction toggle every cycle.
        set_load(0, 0, 0, 0);
        set_load(1, 0, 0, 0);
        load = 1'b1; step(); load = 1'b0;
        dir = 1'b1; step();
        repeat (12) begin
            dir = ~dir;
            step();
        end
        dir = 1'b0;

        // Clamped loads, and a load that coincides with a counting step.
        set_load(0, 31, 63, 63);
        set_load(1, 15, 63, 15);
        load = 1'b1; step(); load = 1'b0;
        step();
        set_load(0, 5, 6, 7);
        set_load(1, 5, 6, 7);
        load = 1'b1; step(); load = 1'b0;
        step();

        // Start and stop together in HALT stays halted; stop in RUN freezes the counts.
        stop = 1'b1; step(); stop = 1'b0;
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        repeat (3) step();
        start = 1'b1; step(); start = 1'b0;
        repeat (4) step();
        stop = 1'b1; step(); stop = 1'b0;
        repeat (3) step();

        // Reset in the middle of a run at 12:34:56 with competing load and start.
        start = 1'b1; step(); start = 1'b0;
        set_load(0, 12, 34, 56);
        set_load(1, 11, 34, 6);
        load = 1'b1; step(); load = 1'b0;
        repeat (2) step();
        rst_n = 1'b0; load = 1'b1; start = 1'b1; step();
        rst_n = 1'b1; load = 1'b0; start = 1'b0;
        step();

        // Randomised control traffic.
        for (int n = 0; n < 600; n++) begin
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 15) == 0);
            dir   = ($urandom_range(0, 3) == 0) ? ~dir : dir;
            load  = ($urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            set_load(0, $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
            set_load(1, $urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 15));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
